// File: rtl/mux_rr_sel_ctrl.sv
// Round-robin arbiter driving a channel mux select, capturing the selected
// mux output and forwarding it downstream with a valid/ready handshake.
module mux_rr_sel_ctrl #(
   parameter int NUM_CH = 31,
   parameter int SEL_W  = 5,
   parameter int DATA_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
   output logic [SEL_W-1:0]  sel,
   input  logic [DATA_W-1:0] mux_data,
   output logic [NUM_CH-1:0] ack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SEL_W-1:0]  out_ch,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_HOLD
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [SEL_W-1:0]    r_sel;
   logic [SEL_W-1:0]    r_ptr;
   logic [SEL_W-1:0]    r_out_ch;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_valid;
   logic [NUM_CH-1:0]   r_ack;
   logic [SEL_W-1:0]    w_winner;
   logic [SEL_W-1:0]    w_scan_idx;
   logic                w_found;
   logic                w_handshake;

   // First requester strictly after the pointer, wrapping at NUM_CH-1.
   // NOTE: every always_comb output gets a default first, otherwise a path
   // that skips the assignment infers a latch.
   always_comb begin
      w_found    = 1'b0;
      w_winner   = '0;
      w_scan_idx = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         w_scan_idx = SEL_W'((int'(r_ptr) + k) % NUM_CH);
         if (!w_found && req[w_scan_idx]) begin
            w_found  = 1'b1;
            w_winner = w_scan_idx;
         end
      end
   end

   assign w_handshake = (r_state == S_HOLD) && r_out_valid && out_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_found) w_next = S_SETTLE;
         S_SETTLE:  w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_HOLD;
         S_HOLD:    if (w_handshake) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // The pointer moves only on handshake so a stalled grant keeps its priority slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel       <= '0;
         r_ptr       <= SEL_W'(NUM_CH - 1);
         r_out_ch    <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_ack       <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found) r_sel <= w_winner;
            end
            S_CAPTURE: begin
               r_out_data  <= mux_data;
               r_out_ch    <= r_sel;
               r_out_valid <= 1'b1;
            end
            S_HOLD: begin
               if (w_handshake) begin
                  r_ack       <= NUM_CH'(1) << r_out_ch;
                  r_out_valid <= 1'b0;
                  r_ptr       <= r_out_ch;
               end
            end
            default: ;
         endcase
      end
   end

   assign sel       = r_sel;
   assign ack       = r_ack;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/mux_rr_sel_ctrl.md
Name: mux_rr_sel_ctrl

Overview:
- Round-robin arbiter and capture controller that sits directly upstream of the 31-way, 2-bit channel mux.
- Picks one requesting channel and drives the mux select with it.
- Registers the selected 2-bit mux output and presents it downstream with a valid/ready handshake.
- Acknowledges the served channel with a one-cycle pulse.

Parameters:
- NUM_CH, 31, number of request channels / mux inputs (1..32).
- SEL_W, 5, select width; must satisfy 2**SEL_W >= NUM_CH.
- DATA_W, 2, width of mux data returned and forwarded.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_CH  per-channel service request, level; bit i = channel i.
- sel  output  SEL_W  mux select; binary channel index 0..NUM_CH-1.
- mux_data  input  DATA_W  combinational mux output for the current sel.
- ack  output  NUM_CH  one-hot, one-cycle pulse when channel transfer completes.
- out_valid  output  1  out_data/out_ch hold a captured sample.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_data  output  DATA_W  captured mux data.
- out_ch  output  SEL_W  channel index the sample came from.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync-release usage assumed by the top level): state=IDLE, sel=0, ack=0, out_valid=0, out_data=0, out_ch=0, busy=0, rr pointer=NUM_CH-1, so channel 0 has first priority.
- FSM states: IDLE, SETTLE, CAPTURE, HOLD.
- IDLE, req==0: stay in IDLE; sel holds its last value.
- IDLE, any req bit set: the winner is the first set bit searched from pointer+1 upward, wrapping NUM_CH-1 to 0. Register sel=winner and go to SETTLE.
- SETTLE: one full cycle with sel stable so the mux output settles; then go to CAPTURE.
- CAPTURE: out_data<=mux_data, out_ch<=sel, out_valid<=1; then go to HOLD.
- HOLD: sel is held constant.
- HOLD, out_valid && out_ready sampled high: ack[out_ch] pulses for exactly that next cycle, out_valid<=0, pointer<=out_ch, go to IDLE.
- HOLD, out_ready low: stay in HOLD indefinitely; out_data and out_ch stay stable.
- Latency from req seen in IDLE to out_valid high: 3 clock edges.
- Minimum spacing between back-to-back grants: 4 cycles (IDLE is always visited for 1 cycle).
- The pointer updates only on handshake completion, never on grant.
- A req that drops after grant does not cancel the transfer: the sample is still captured, delivered and acked.
- A req bit held continuously is served again only after every other requesting channel has had a turn.
- Single requester: it is re-granted each time it returns to IDLE.
- Simultaneous handshake and new req: the new req is evaluated in the following IDLE cycle, with the pointer already updated.
- req bits at index >= NUM_CH do not exist. sel never takes values >= NUM_CH.
- Reset mid-transfer: all outputs return immediately to their reset values. No ack is issued for the aborted transfer. The pointer returns to NUM_CH-1.
- out_valid is not combinationally dependent on out_ready. ack is registered.

Test Plan:
- Reset with req=31'h7FFFFFFF → sel=0, out_valid=0, ack=0. After release, the first grant is ch0; ch0 captures mux_data=2'b10 → out_valid on the 3rd edge, out_ch=0, out_data=2'b10.
- req bits 3, 7, 30 held, out_ready=1 → grant order 3, 7, 30, 3, 7 … Each ack is a single-cycle pulse on the matching bit. out_data matches the mux input driven per channel (ch3=01, ch7=11, ch30=10).
- Wrap-around: serve ch30, then req bits 0 and 29 set → next grant ch0, then ch29.
- Backpressure: out_ready=0 for 10 cycles after out_valid → sel, out_data and out_ch stable throughout, no ack. Then out_ready=1 for one cycle → ack pulse on that channel, out_valid drops, busy drops.
- Request withdrawn: ch5 granted, req[5] drops during SETTLE → the sample is still captured and delivered, and ack[5] pulses.
- Reset mid-HOLD: rst_n low while out_valid=1 → out_valid=0, ack=0, sel=0 asynchronously. After release with req bits 0 and 4, the first grant is ch0.
